// File: rtl/crossbar_edge_counter.sv
// -----------------------------------------------------------------------------
// crossbar_edge_counter
//
// Purpose:
//   Monitors the registered outputs of the 8-channel crossbar. Each enabled
//   channel has a saturating edge counter and a sticky edge flag. The live
//   line levels are also exposed. Everything is read and written by the
//   picosoc CPU over the iomem bus. The block decodes its own address window,
//   which is selected by iomem_addr[31:24] == BASE_ADDR.
//
// Optional feature:
//   Define EDGE_COUNT_POLARITY_EN to add the POLARITY register at offset 11.
//   A POLARITY bit of 1 makes its channel count falling edges.
//   With the macro undefined, offset 11 reads 0, writes to it are ignored,
//   and only rising edges are counted.
//
// Ports:
//   clkIn        clock; all state updates on the rising edge
//   resetn       synchronous active-low reset
//   ch_in        monitored crossbar lines (already in the clkIn domain)
//   iomem_valid  bus request
//   iomem_ready  one-cycle acknowledge, 1 cycle after the request is seen
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte address; [31:24] selects the window, [5:2] selects
//                the register
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is 1
//   any_flag     registered OR of all FLAGS bits (irq source)
//
// Register map (word offset = iomem_addr[5:2]):
//   0..7  CNTn      read counter, write with any strobe clears it
//   8     FLAGS     write-1-to-clear (byte 0)
//   9     ENABLE    read/write (byte 0)
//   10    LEVEL     read-only live ch_in
//   11    POLARITY  read/write (byte 0) when EDGE_COUNT_POLARITY_EN is defined
//   12-15 reserved, read 0
// -----------------------------------------------------------------------------
module crossbar_edge_counter #(
  parameter int          NUM_CH    = 8,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h04
) (
  input  logic              clkIn,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              any_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // State
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              any_flag_q, any_flag_d;
`ifdef EDGE_COUNT_POLARITY_EN
  logic [NUM_CH-1:0] polarity_q, polarity_d;
`endif

  // Bus decode
  logic              sel;
  logic              wr_en;
  logic              byte0_wr;
  logic [3:0]        offset;
  logic [31:0]       rd_mux;
  logic [NUM_CH-1:0] edge_det;

  // Address bits outside the decoded fields, and wdata bits above NUM_CH,
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, iomem_addr[23:6], iomem_addr[1:0], iomem_wdata};

  // The ~ready_q term makes a held request complete once, not every cycle.
  assign sel      = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE_ADDR);
  assign wr_en    = sel & (|iomem_wstrb);
  assign byte0_wr = wr_en & iomem_wstrb[0];
  assign offset   = iomem_addr[5:2];

  // Edge detection. prev_q tracks ch_in even while a channel is disabled.
  // This way, enabling a channel whose line is already high produces no edge.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_edge
`ifdef EDGE_COUNT_POLARITY_EN
    assign edge_det[gi] = enable_q[gi] &
                          (polarity_q[gi] ? (~ch_in[gi] &  prev_q[gi])
                                          : ( ch_in[gi] & ~prev_q[gi]));
`else
    assign edge_det[gi] = enable_q[gi] & ch_in[gi] & ~prev_q[gi];
`endif
  end

  // Read mux. Counter offsets at or above NUM_CH fall through to 0.
  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (offset == 4'(i)) begin
        rd_mux = 32'(cnt_q[i]);
      end
    end
    case (offset)
      4'd8:    rd_mux = 32'(flags_q);
      4'd9:    rd_mux = 32'(enable_q);
      4'd10:   rd_mux = 32'(ch_in);
`ifdef EDGE_COUNT_POLARITY_EN
      4'd11:   rd_mux = 32'(polarity_q);
`endif
      default: ;
    endcase
  end

  // Counters: a software clear beats a coincident edge, and an edge at
  // all-ones leaves the counter where it is.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en && (offset == 4'(i))) begin
        cnt_d[i] = '0;
      end else if (edge_det[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    prev_d     = ch_in;
    ready_d    = sel;
    rdata_d    = sel ? rd_mux : rdata_q;
    any_flag_d = |flags_q;
    enable_d   = enable_q;
    if (byte0_wr && (offset == 4'd9)) begin
      enable_d = iomem_wdata[NUM_CH-1:0];
    end
    // The set is applied after the clear, so a new edge survives a W1C
    // that lands in the same cycle.
    flags_d = flags_q;
    if (byte0_wr && (offset == 4'd8)) begin
      flags_d = flags_q & ~iomem_wdata[NUM_CH-1:0];
    end
    flags_d = flags_d | edge_det;
`ifdef EDGE_COUNT_POLARITY_EN
    polarity_d = polarity_q;
    if (byte0_wr && (offset == 4'd11)) begin
      polarity_d = iomem_wdata[NUM_CH-1:0];
    end
`endif
  end

  always_ff @(posedge clkIn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      flags_q    <= '0;
      enable_q   <= '0;
      prev_q     <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      any_flag_q <= 1'b0;
`ifdef EDGE_COUNT_POLARITY_EN
      polarity_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      flags_q    <= flags_d;
      enable_q   <= enable_d;
      prev_q     <= prev_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      any_flag_q <= any_flag_d;
`ifdef EDGE_COUNT_POLARITY_EN
      polarity_q <= polarity_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign any_flag    = any_flag_q;

endmodule

// File: tb/tb_crossbar_edge_counter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for crossbar_edge_counter. The DUT is built with
// CNT_W=4 so that saturation is reachable in a few pulses. A table of
// bus/stimulus records drives the main flow. Short hand-written sequences
// cover the multi-cycle corners: acknowledge timing, races, enabling while
// a line is high, reset during a transfer, and polarity.
// -----------------------------------------------------------------------------
module tb_crossbar_edge_counter;

  localparam int         NUM_CH = 8;
  localparam int         CNT_W  = 4;
  localparam logic [7:0] BASE   = 8'h04;

  logic              clkIn;
  logic              resetn;
  logic [NUM_CH-1:0] ch_in;
  logic              iomem_valid;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb;
  logic [31:0]       iomem_addr;
  logic [31:0]       iomem_wdata;
  logic [31:0]       iomem_rdata;
  logic              any_flag;

  int checks = 0;
  int errors = 0;

  crossbar_edge_counter #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clkIn       (clkIn),
    .resetn      (resetn),
    .ch_in       (ch_in),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .any_flag    (any_flag)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_RD, OP_WR, OP_PULSE, OP_LVL, OP_IDLE, OP_ANY} op_e;

  typedef struct {
    op_e         op;
    logic [3:0]  off;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input op_e op, input logic [3:0] off, input logic [3:0] strb,
                     input logic [31:0] data, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.off = off; v.strb = strb; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Must be called on a falling edge. Returns on a falling edge, one cycle
  // after the acknowledge, having checked both the acknowledge latency and
  // its one-cycle width.
  task automatic bus_xfer(input logic [3:0] off, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rd);
    int n;
    iomem_valid = 1'b1;
    iomem_addr  = {BASE, 18'd0, off, 2'b00};
    iomem_wstrb = strb;
    iomem_wdata = wd;
    n = 0;
    do begin
      @(negedge clkIn);
      n++;
    end while (!iomem_ready && n < 8);
    check("ack_latency", 32'(n), 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    @(negedge clkIn);
    check("ack_width", {31'd0, iomem_ready}, 32'd0);
    $display("bus %s off=%0d strb=%h wdata=%08h rdata=%08h",
             (strb != 4'd0) ? "WR" : "RD", off, strb, wd, rd);
  endtask

  task automatic bus_read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(off, 4'd0, 32'd0, rd);
    check(name, rd, exp);
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(off, strb, wd, rd);
  endtask

  task automatic pulse(input int ch, input int count);
    for (int p = 0; p < count; p++) begin
      ch_in[ch] = 1'b1;
      @(negedge clkIn);
      ch_in[ch] = 1'b0;
      @(negedge clkIn);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;

    resetn      = 1'b0;
    ch_in       = '0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clkIn);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_any_flag", {31'd0, any_flag}, 32'd0);
    resetn = 1'b1;
    @(negedge clkIn);

    // Main table
    for (int i = 0; i < 8; i++) add(OP_RD, 4'(i), 4'h0, 32'd0, 32'd0);
    add(OP_RD,    4'd8,  4'h0, 32'd0,  32'd0);
    add(OP_RD,    4'd9,  4'h0, 32'd0,  32'd0);
    add(OP_RD,    4'd11, 4'h0, 32'd0,  32'd0);
    add(OP_RD,    4'd12, 4'h0, 32'd0,  32'd0);
    add(OP_LVL,   4'd0,  4'h0, 32'hA5, 32'd0);
    add(OP_RD,    4'd10, 4'h0, 32'd0,  32'hA5);
    add(OP_LVL,   4'd0,  4'h0, 32'h00, 32'd0);
    add(OP_RD,    4'd10, 4'h0, 32'd0,  32'h00);
    add(OP_WR,    4'd9,  4'h1, 32'h01, 32'd0);
    add(OP_PULSE, 4'd0,  4'h0, 32'd5,  32'd0);
    add(OP_PULSE, 4'd1,  4'h0, 32'd3,  32'd0);
    add(OP_RD,    4'd0,  4'h0, 32'd0,  32'd5);
    add(OP_RD,    4'd1,  4'h0, 32'd0,  32'd0);
    add(OP_RD,    4'd8,  4'h0, 32'd0,  32'h01);
    add(OP_ANY,   4'd0,  4'h0, 32'd0,  32'd1);
    add(OP_WR,    4'd9,  4'h1, 32'hFF, 32'd0);
    add(OP_PULSE, 4'd3,  4'h0, 32'd20, 32'd0);
    add(OP_RD,    4'd3,  4'h0, 32'd0,  32'd15);
    add(OP_RD,    4'd8,  4'h0, 32'd0,  32'h09);
    add(OP_PULSE, 4'd1,  4'h0, 32'd2,  32'd0);
    add(OP_RD,    4'd1,  4'h0, 32'd0,  32'd2);
    add(OP_WR,    4'd1,  4'h8, 32'd0,  32'd0);
    add(OP_RD,    4'd1,  4'h0, 32'd0,  32'd0);
    add(OP_WR,    4'd9,  4'h2, 32'h00, 32'd0);
    add(OP_RD,    4'd9,  4'h0, 32'd0,  32'hFF);
    add(OP_WR,    4'd8,  4'h2, 32'hFF, 32'd0);
    add(OP_RD,    4'd8,  4'h0, 32'd0,  32'h0B);
    add(OP_WR,    4'd8,  4'h1, 32'hFF, 32'd0);
    add(OP_IDLE,  4'd0,  4'h0, 32'd2,  32'd0);
    add(OP_RD,    4'd8,  4'h0, 32'd0,  32'h00);
    add(OP_ANY,   4'd0,  4'h0, 32'd0,  32'd0);
    add(OP_WR,    4'd0,  4'h1, 32'd0,  32'd0);
    add(OP_RD,    4'd0,  4'h0, 32'd0,  32'd0);
    add(OP_WR,    4'd15, 4'hF, 32'hFF, 32'd0);
    add(OP_RD,    4'd15, 4'h0, 32'd0,  32'd0);
    add(OP_RD,    4'd3,  4'h0, 32'd0,  32'd15);

    for (int k = 0; k < vecs.size(); k++) begin
      case (vecs[k].op)
        OP_RD:    bus_read_check($sformatf("vec%0d_rd_off%0d", k, vecs[k].off), vecs[k].off, vecs[k].exp);
        OP_WR:    bus_write(vecs[k].off, vecs[k].strb, vecs[k].data);
        OP_PULSE: pulse(int'(vecs[k].off), int'(vecs[k].data));
        OP_LVL:   begin ch_in = vecs[k].data[NUM_CH-1:0]; @(negedge clkIn); end
        OP_IDLE:  repeat (int'(vecs[k].data)) @(negedge clkIn);
        OP_ANY:   check($sformatf("vec%0d_any_flag", k), {31'd0, any_flag}, vecs[k].exp);
        default:  ;
      endcase
    end

    // any_flag trails FLAGS by one cycle (ENABLE is 0xFF here)
    ch_in[6] = 1'b1;
    @(negedge clkIn);
    check("any_flag_lag", {31'd0, any_flag}, 32'd0);
    @(negedge clkIn);
    check("any_flag_set", {31'd0, any_flag}, 32'd1);
    ch_in[6] = 1'b0;
    bus_write(4'd8, 4'h1, 32'hFF);
    check("any_flag_clr", {31'd0, any_flag}, 32'd0);

    // Foreign address window is never acknowledged
    iomem_valid = 1'b1;
    iomem_addr  = {8'h05, 24'h000024};
    iomem_wstrb = 4'd0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clkIn);
      seen = seen | iomem_ready;
    end
    check("foreign_no_ack", {31'd0, seen}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clkIn);

    // Held request: acknowledged every other cycle
    iomem_valid = 1'b1;
    iomem_addr  = {BASE, 18'd0, 4'd9, 2'b00};
    @(negedge clkIn);
    check("b2b_ack1", {31'd0, iomem_ready}, 32'd1);
    check("b2b_rdata", iomem_rdata, 32'hFF);
    @(negedge clkIn);
    check("b2b_gap1", {31'd0, iomem_ready}, 32'd0);
    @(negedge clkIn);
    check("b2b_ack2", {31'd0, iomem_ready}, 32'd1);
    @(negedge clkIn);
    check("b2b_gap2", {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clkIn);

    // Counter clear in the same cycle as an edge: clear wins
    pulse(2, 3);
    bus_read_check("race_cnt2_pre", 4'd2, 32'd3);
    ch_in[2] = 1'b1;
    bus_write(4'd2, 4'h1, 32'd0);
    bus_read_check("race_cnt2_clear", 4'd2, 32'd0);
    ch_in[2] = 1'b0;
    @(negedge clkIn);
    bus_write(4'd8, 4'h1, 32'hFF);

    // Flag W1C in the same cycle as an edge: set wins
    ch_in[2] = 1'b1;
    bus_write(4'd8, 4'h1, 32'h04);
    bus_read_check("race_flag2", 4'd8, 32'h04);
    ch_in[2] = 1'b0;
    @(negedge clkIn);

    // Enabling a channel whose line is already high gives no edge
    bus_write(4'd9, 4'h1, 32'h00);
    ch_in[4] = 1'b1;
    repeat (2) @(negedge clkIn);
    bus_write(4'd9, 4'h1, 32'h10);
    repeat (2) @(negedge clkIn);
    bus_read_check("en_high_cnt4", 4'd4, 32'd0);
    ch_in[4] = 1'b0;
    @(negedge clkIn);
    ch_in[4] = 1'b1;
    repeat (2) @(negedge clkIn);
    bus_read_check("en_high_cnt4_after", 4'd4, 32'd1);
    ch_in = '0;
    @(negedge clkIn);

    // Reset during an active transfer drops ready and clears state
    iomem_valid = 1'b1;
    iomem_addr  = {BASE, 18'd0, 4'd4, 2'b00};
    iomem_wstrb = 4'd0;
    @(negedge clkIn);
    check("rst_mid_ack", {31'd0, iomem_ready}, 32'd1);
    resetn = 1'b0;
    @(negedge clkIn);
    check("rst_mid_ready_drop", {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clkIn);
    resetn = 1'b1;
    @(negedge clkIn);
    check("rst_mid_any_flag", {31'd0, any_flag}, 32'd0);
    bus_read_check("rst_mid_cnt4", 4'd4, 32'd0);
    bus_read_check("rst_mid_enable", 4'd9, 32'd0);

`ifdef EDGE_COUNT_POLARITY_EN
    // Falling-edge counting on channel 0
    bus_write(4'd11, 4'h1, 32'h01);
    bus_write(4'd9, 4'h1, 32'h01);
    bus_read_check("pol_reg", 4'd11, 32'h01);
    pulse(0, 2);
    bus_read_check("pol_cnt0", 4'd0, 32'd2);
    ch_in[0] = 1'b1;
    @(negedge clkIn);
    bus_read_check("pol_rise_ignored", 4'd0, 32'd2);
    ch_in[0] = 1'b0;
    @(negedge clkIn);
    bus_read_check("pol_fall_counted", 4'd0, 32'd3);
`else
    // Offset 11 is unimplemented; only rising edges count
    bus_write(4'd11, 4'h1, 32'hFF);
    bus_read_check("pol_absent", 4'd11, 32'd0);
    bus_write(4'd9, 4'h1, 32'h01);
    ch_in[0] = 1'b1;
    @(negedge clkIn);
    bus_read_check("rise_counted", 4'd0, 32'd1);
    ch_in[0] = 1'b0;
    @(negedge clkIn);
    bus_read_check("fall_ignored", 4'd0, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_edge_counter.md
Name: crossbar_edge_counter

Overview:
- Downstream consumer of the 8-channel crossbar outputs.
- Counts edges on each routed line independently, keeps sticky per-channel edge flags, and exposes the live line levels.
- Results are read by the picosoc CPU over the iomem bus. The block decodes its own iomem address window, alongside the gpio register block.
- All logic runs in the single clkIn domain. The crossbar outputs are already registered in that domain, so no input synchronisers are used.

Parameters:
- NUM_CH, 8, number of monitored channels (1..8).
- CNT_W, 16, counter width in bits (1..32).
- BASE_ADDR, 8'h04, value that iomem_addr[31:24] must match for this block to respond.

Ports:
- clkIn  input  1  clock; all state updates on its rising edge.
- resetn  input  1  synchronous reset, active-low, sampled on the clkIn rising edge.
- ch_in  input  NUM_CH  crossbar output lines being monitored.
- iomem_valid  input  1  bus request valid.
- iomem_ready  output  1  one-cycle acknowledge pulse.
- iomem_wstrb  input  4  byte write strobes; 0 means read.
- iomem_addr  input  32  byte address.
- iomem_wdata  input  32  write data.
- iomem_rdata  output  32  read data, valid in the cycle iomem_ready is 1.
- any_flag  output  1  OR of all FLAGS bits; intended as an irq source.

Behaviour:
- Reset (resetn=0 at a clock edge) clears:
  - all counters, FLAGS, ENABLE and prev;
  - iomem_ready=0, iomem_rdata=0, any_flag=0.
- Reset asserted mid-transaction drops iomem_ready the following cycle; no write takes effect.
- prev[i] <= ch_in[i] every cycle, regardless of ENABLE. Enabling a channel while its line is high therefore produces no spurious edge.
- Edge detection: edge[i] = ENABLE[i] & ch_in[i] & ~prev[i].
- Count latency: the counter increments at the clock edge where edge[i]=1, and the new value is readable from the next cycle.
- Counters saturate at all-ones; there is no wrap-around.
- FLAGS[i] is set by edge[i] and stays set until cleared by software.
- Bus selection: sel = iomem_valid & ~iomem_ready & (iomem_addr[31:24]==BASE_ADDR).
- Bus timing:
  - On sel, iomem_ready <= 1 for exactly one cycle, otherwise iomem_ready <= 0.
  - iomem_rdata captures the addressed register in that same edge, giving a 1-cycle acknowledge latency.
  - Back-to-back requests are acknowledged every other cycle.
- Register map, offset = iomem_addr[5:2]:
  - 0..7, CNTn: read returns the zero-extended counter. A write with any strobe set clears that counter. Offsets at or above NUM_CH read 0.
  - 8, FLAGS[7:0]: write-1-to-clear, gated by wstrb[0].
  - 9, ENABLE[7:0]: read/write, gated by wstrb[0].
  - 10, LEVEL: read-only, returns the current ch_in.
  - 11, POLARITY: see Optional Feature.
  - 12..15: read 0, writes ignored.
- Read/write same cycle: rdata returns the pre-write value.
- Simultaneous clear and edge on a counter: clear wins, the counter becomes 0 and that edge is lost.
- Simultaneous W1C and edge on a flag: set wins, the flag stays 1.
- A saturated counter stays at all-ones on further edges; FLAGS is still set.
- any_flag is registered, so it follows FLAGS with 1 cycle of latency.

Optional Feature:
- Macro: EDGE_COUNT_POLARITY_EN.
- Defined:
  - Offset 11 is POLARITY[7:0]: read/write, gated by wstrb[0], reset 0.
  - POLARITY[i]=0 counts rising edges, as described above.
  - POLARITY[i]=1 counts falling edges: edge[i] = ENABLE[i] & ~ch_in[i] & prev[i].
  - Changing POLARITY while a line is steady produces no edge.
- Undefined: offset 11 reads 0, writes are ignored, and only rising edges are counted. The POLARITY register is not synthesised.

Test Plan:
1. Reset release: read CNT0..7, FLAGS, ENABLE -> all return 0; iomem_ready asserts exactly 1 cycle after valid.
2. Basic counting:
   - Stimulus: ENABLE=0x01, then drive 5 rising pulses on ch_in[0] and 3 on ch_in[1].
   - Response: CNT0=5, CNT1=0, FLAGS=0x01, any_flag=1.
3. Saturation (CNT_W=4): ENABLE=0xFF, 20 pulses on ch_in[3] -> CNT3=15.
4. Clear races:
   - Write CNT2 in the same cycle as an edge on ch_in[2] -> CNT2=0.
   - Write FLAGS=0x04 in the same cycle as an edge -> FLAGS bit 2 remains 1.
5. Enable while high: hold ch_in[4]=1, then write ENABLE=0x10 -> CNT4 stays 0. After a subsequent 1->0->1 on ch_in[4], CNT4=1.
6. With EDGE_COUNT_POLARITY_EN:
   - POLARITY=0x01 and ENABLE=0x01; drive ch_in[0] 0->1->0 twice -> CNT0=2, counted on the falling edges.
   - Without the macro, a read of offset 11 returns 0.
